// File: rtl/bus_select_arbiter.sv
// rtl/bus_select_arbiter.sv - registered bus-drive arbiter producing one-hot grant and binary mux select
//
// Ports:
//   clk          in   rising-edge clock
//   clr          in   asynchronous active-low reset
//   req          in   N drive requests, bit i = source i wants the bus
//   rr_en        in   1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
//   lock         in   hold the current owner while its request stays asserted
//   cnt_clr      in   synchronous clear of conflict_cnt
//   select       out  binary index of the granted source, DEFAULT_SEL when idle
//   grant        out  one-hot grant, all-zero when idle
//   valid        out  a source is granted
//   conflict     out  previous cycle had two or more requests
//   conflict_cnt out  saturating count of conflict cycles

module bus_select_arbiter #(
  parameter int N           = 24,
  parameter int SEL_W       = 6,
  parameter int DEFAULT_SEL = 31,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     req,
  input  logic             rr_en,
  input  logic             lock,
  input  logic             cnt_clr,
  output logic [SEL_W-1:0] select,
  output logic [N-1:0]     grant,
  output logic             valid,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]     ONE_N = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [SEL_W-1:0] owner_d, select_d, win_idx;
  logic [N-1:0]     grant_d;
  logic [CNT_W-1:0] cnt_d;
  logic             take_win, owner_req, multi, any_req;

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot, scan;
  logic             win_found;
  int               win_pos;

  assign any_req   = |req;
  // The registered grant is one-hot on the current owner, so this picks req[owner].
  assign owner_req = |(req & grant);
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi     = |(req & (req - ONE_N));
  assign valid     = (state != IDLE);

  // Arbiter: rotate the request vector so the round-robin pointer sits at bit 0,
  // take the lowest set bit, then rotate the position back. Fixed priority is
  // the same search with no rotation.
  always_comb begin
    req_dbl   = {req, req} >> (rr_en ? ptr : '0);
    req_rot   = req_dbl[N-1:0];
    win_found = 1'b0;
    win_pos   = 0;
    scan      = '0;
    for (int k = 0; k < N; k++) begin
      scan = req_rot >> k;
      if (!win_found && scan[0]) begin
        win_found = 1'b1;
        win_pos   = k;
      end
    end
    if (rr_en) win_pos = win_pos + int'(ptr);
    if (win_pos >= N) win_pos = win_pos - N;
    win_idx = SEL_W'(win_pos);
  end

  // Next-state logic. take_win marks a fresh arbitration; only those move the
  // owner and advance the round-robin pointer.
  always_comb begin
    state_d  = state;
    take_win = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          take_win = 1'b1;
          state_d  = lock ? HOLD : GRANT;
        end
      end
      GRANT: begin
        if (!any_req) begin
          state_d = IDLE;
        end else if (lock && owner_req) begin
          state_d = HOLD;
        end else begin
          take_win = 1'b1;
          state_d  = GRANT;
        end
      end
      HOLD: begin
        if (lock && owner_req) begin
          state_d = HOLD;
        end else if (any_req) begin
          take_win = 1'b1;
          state_d  = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    owner_d = select;
    if (take_win) owner_d = win_idx;

    ptr_d = ptr;
    if (take_win && rr_en) ptr_d = (win_pos == N - 1) ? '0 : PTR_W'(win_pos + 1);
  end

  // Output logic: values presented after the next edge.
  always_comb begin
    if (state_d == IDLE) begin
      grant_d  = '0;
      select_d = SEL_W'(DEFAULT_SEL);
    end else begin
      grant_d  = ONE_N << owner_d;
      select_d = owner_d;
    end

    cnt_d = conflict_cnt;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (multi && (conflict_cnt != {CNT_W{1'b1}})) begin
      cnt_d = conflict_cnt + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= IDLE;
      ptr          <= '0;
      select       <= SEL_W'(DEFAULT_SEL);
      grant        <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      select       <= select_d;
      grant        <= grant_d;
      conflict     <= multi;
      conflict_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// tb/tb_bus_select_arbiter.sv - self-checking bench for bus_select_arbiter

module tb_bus_select_arbiter;

  localparam int N   = 24;
  localparam int DEF = 31;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  req = '0;
  logic          rr_en = 1'b0;
  logic          lock = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [5:0]    select;
  logic [N-1:0]  grant;
  logic          valid;
  logic          conflict;
  logic [7:0]    conflict_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 = nobody), frozen flag, pointer, counter.
  int m_owner = -1;
  bit m_hold  = 1'b0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_conf  = 1'b0;

  bus_select_arbiter #(.N(N), .SEL_W(6), .DEFAULT_SEL(DEF), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .req(req), .rr_en(rr_en), .lock(lock), .cnt_clr(cnt_clr),
    .select(select), .grant(grant), .valid(valid), .conflict(conflict),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int arb(input logic [N-1:0] r, input bit rr, input int p);
    for (int k = 0; k < N; k++) begin
      int i = rr ? (p + k) % N : k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_hold = 1'b0; m_ptr = 0; m_cnt = 0; m_conf = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input bit lk, input bit rr, input bit cc);
    bit any  = (r != 0);
    int pc   = $countones(r);
    bit oreq = (m_owner >= 0) && (((r >> m_owner) & 24'd1) != 0);
    bit was_idle = (m_owner < 0);
    bit do_arb = 1'b0;
    int w;
    if (was_idle) begin
      if (any) do_arb = 1'b1;
    end else if (lk && oreq) begin
      m_hold = 1'b1;
    end else if (any) begin
      do_arb = 1'b1;
    end else begin
      m_owner = -1;
      m_hold  = 1'b0;
    end
    if (do_arb) begin
      w = arb(r, rr, m_ptr);
      m_owner = w;
      m_hold  = was_idle ? lk : 1'b0;
      if (rr) m_ptr = (w + 1) % N;
    end
    m_conf = (pc >= 2);
    if (cc) m_cnt = 0;
    else if (pc >= 2 && m_cnt < 255) m_cnt++;
  endtask

  task automatic check_all();
    logic [N-1:0] eg = (m_owner >= 0) ? (24'd1 << m_owner) : 24'd0;
    chk("select", 32'(select), (m_owner >= 0) ? 32'(m_owner) : 32'(DEF));
    chk("grant", 32'(grant), 32'(eg));
    chk("valid", 32'(valid), 32'(m_owner >= 0));
    chk("conflict", 32'(conflict), 32'(m_conf));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
  endtask

  task automatic cyc(input logic [N-1:0] r, input bit lk, input bit rr, input bit cc);
    req = r; lock = lk; rr_en = rr; cnt_clr = cc;
    @(posedge clk);
    model_step(r, lk, rr, cc);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    #1;
    model_reset();
    chk("rst_select", 32'(select), 32'(DEF));
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_cnt", 32'(conflict_cnt), 0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    bit lk, rr, cc;

    do_reset();
    chk("rst_conflict", 32'(conflict), 0);

    // Single request, then idle.
    cyc(24'h000001, 0, 0, 0);
    chk("single_sel", 32'(select), 0);
    chk("single_grant", 32'(grant), 32'h1);
    cyc(24'h000000, 0, 0, 0);
    chk("idle_sel", 32'(select), 31);

    // Fixed priority with a two-source conflict.
    cyc(24'h000C00, 0, 0, 0);
    chk("fixed_sel", 32'(select), 10);
    chk("fixed_cnt1", 32'(conflict_cnt), 1);
    for (int i = 0; i < 3; i++) cyc(24'h000C00, 0, 0, 0);
    chk("fixed_cnt4", 32'(conflict_cnt), 4);

    // Round-robin rotation and wrap.
    do_reset();
    cyc(24'h000007, 0, 1, 0); chk("rr0", 32'(select), 0);
    cyc(24'h000007, 0, 1, 0); chk("rr1", 32'(select), 1);
    cyc(24'h000007, 0, 1, 0); chk("rr2", 32'(select), 2);
    cyc(24'h000007, 0, 1, 0); chk("rr3", 32'(select), 0);
    cyc(24'h800001, 0, 1, 0); chk("rr_hi", 32'(select), 23);
    cyc(24'h800001, 0, 1, 0); chk("rr_wrap", 32'(select), 0);

    // Lock holds owner 5 even when a lower index requests.
    do_reset();
    cyc(24'h000020, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(24'h000060, 1, 0, 0);
      chk("hold5", 32'(select), 5);
    end
    cyc(24'h000030, 1, 0, 0); chk("hold_low", 32'(select), 5);
    cyc(24'h000040, 1, 0, 0); chk("hold_drop", 32'(select), 6);
    cyc(24'h000041, 0, 0, 0); chk("unlock", 32'(select), 0);

    // Counter saturation and clear priority.
    for (int i = 0; i < 300; i++) cyc(24'h000003, 0, 0, 0);
    chk("cnt_sat", 32'(conflict_cnt), 255);
    cyc(24'h000003, 0, 0, 1);
    chk("cnt_clr", 32'(conflict_cnt), 0);

    // Asynchronous reset while granted.
    cyc(24'h000200, 0, 0, 0);
    chk("pre_rst9", 32'(select), 9);
    #2;
    clr = 1'b0;
    #1;
    model_reset();
    chk("async_grant", 32'(grant), 0);
    chk("async_sel", 32'(select), 31);
    chk("async_valid", 32'(valid), 0);
    @(negedge clk);
    clr = 1'b1;
    cyc(24'h000200, 0, 0, 0);
    chk("post_rst9", 32'(select), 9);

    // Randomized traffic against the model.
    r = '0; lk = 1'b0; rr = 1'b0; cc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: r = '0;
        1: r = 24'd1 << $urandom_range(0, N - 1);
        2: r = (24'd1 << $urandom_range(0, N - 1)) | (24'd1 << $urandom_range(0, N - 1));
        3: r = 24'($urandom);
        4: r = r ^ (24'd1 << $urandom_range(0, N - 1));
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      if ($urandom_range(0, 31) == 0) rr = ~rr;
      cc = ($urandom_range(0, 49) == 0);
      cyc(r, lk, rr, cc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_select_arbiter.md
# bus_select_arbiter

Registered, parametrised successor to the datapath bus-mux select encoder. Takes N bus-drive request lines (register/ALU "out" enables) and produces a one-hot grant plus binary select code for the bus multiplexer. It resolves multi-hot requests by fixed-priority or round-robin arbitration rather than falling to the default code, and can lock the bus to the current owner. It flags and counts drive conflicts for debug, and sits between the control unit and the bus mux select input.

## Interface
- N, 24: number of bus sources; 2 ≤ N ≤ 2^SEL_W − 1
- SEL_W, 6: select code width
- DEFAULT_SEL, 31: code driven when no source is granted; must be ≥ N
- CNT_W, 8: conflict counter width
- clk  in  1  system clock, rising-edge
- clr  in  1  asynchronous active-low reset
- req  in  N  drive requests, bit i = source i wants the bus
- rr_en  in  1  1 = round-robin, 0 = fixed priority (lowest index wins)
- lock  in  1  hold current grant while its requester stays asserted
- cnt_clr  in  1  synchronous clear of conflict_cnt
- select  out  SEL_W  binary index of granted source, else DEFAULT_SEL
- grant  out  N  one-hot grant, all-zero when idle
- valid  out  1  a source is granted
- conflict  out  1  previous cycle had ≥2 requests
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

## Operation
- FSM states: IDLE (valid=0), GRANT (valid=1, re-arbitrates every cycle), HOLD (valid=1, grant frozen).
- IDLE: req==0 stays IDLE. Otherwise arbitrate into GRANT, or into HOLD if lock=1.
- GRANT: req==0 goes to IDLE. lock=1 with req[owner]=1 goes to HOLD, keeping the owner. Otherwise re-arbitrate and stay in GRANT.
- HOLD: lock=1 and req[owner]=1 keeps the same grant. When lock drops, or req[owner] drops, re-arbitrate the same cycle: go to GRANT, or to IDLE if req==0. Other requests are ignored for the grant while in HOLD; they still count toward conflict.
- Fixed priority (rr_en=0): winner is the lowest set index. A single-hot req gives select = its index, matching the legacy encoder.
- Round-robin (rr_en=1): winner is the first set bit at index ≥ ptr, scanning upward and wrapping N−1 → 0.
  - ptr is a ⌈log2 N⌉-bit register, reset 0.
  - On every new arbitration win at index i, ptr ← (i+1) mod N. ptr does not update while in HOLD, or in fixed mode.
- Changing rr_en mid-operation takes effect at the next arbitration; ptr retains its value.
- Conflict: conflict ← (popcount(req) ≥ 2), evaluated every cycle in every state.
- conflict_cnt:
  - increments when popcount(req) ≥ 2;
  - saturates at 2^CNT_W − 1;
  - cnt_clr=1 forces it to 0 and takes priority over a simultaneous increment.
- select always equals the encoded index of grant; it is DEFAULT_SEL when grant==0.

## Timing
- All outputs are registered. Latency is 1 cycle from req/lock/rr_en change to grant/select/valid/conflict.
- Reset (clr=0, asynchronous) forces:
  - state=IDLE, ptr=0;
  - select=DEFAULT_SEL, grant=0, valid=0, conflict=0, conflict_cnt=0.
- Outputs stay at reset values until the first rising clk edge after clr deasserts.
- Reset mid-HOLD or mid-GRANT drops the grant immediately, without waiting for a clock.
- A requester dropping at edge k yields a new owner or IDLE at edge k+1. There is no dead cycle between owners.
- No combinational path from any input to any output.

## Test plan
- Reset, then req=0x000001 for one cycle → next cycle select=0, grant=0x000001, valid=1. Then req=0 → select=31, grant=0, valid=0.
- Fixed priority, req=0x000C00 (sources 10, 11) → select=10, conflict=1, conflict_cnt=1. Three more identical cycles → conflict_cnt=4.
- rr_en=1, req=0x000007 held 4 cycles → select sequence 0,1,2,0. Then req=0x800001 with ptr=1 → select=23, ptr wraps to 0.
- lock=1 with owner 5 and req=0x000060 for 3 cycles → select stays 5 (HOLD). Drop req bit 5 → next cycle select=6, state GRANT.
- CNT_W=8 with 300 conflict cycles → conflict_cnt=255. Assert cnt_clr together with a conflict → conflict_cnt=0.
- Assert clr asynchronously between edges while valid=1, owner 9 → grant=0, select=31, valid=0 before the next edge. After release, req=0x000200 → select=9 one cycle later.
